// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB master bridge.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        DONE
    } apb_state_e;

    localparam int PROT_WIDTH = 3;

    function automatic int strb_width(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/apb_slave_decoder.sv
// Turns the slave-index field of an address into a one-hot select and flags indices with no completer behind them.
module apb_slave_decoder #(
    parameter int NUM_SLAVES = 4,
    parameter int SEL_BITS   = 2
) (
    input  logic [SEL_BITS-1:0]   idx,
    output logic [NUM_SLAVES-1:0] sel,
    output logic                  decode_err
);

    generate
        for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_sel
            assign sel[gi] = (idx == SEL_BITS'(gi));
        end
    endgenerate

    assign decode_err = (int'(idx) >= NUM_SLAVES);

endmodule

// File: rtl/apb_master_bridge.sv
// APB4 master: single-outstanding command/response in, address-decoded APB transfers out.
// Optional ACCESS-phase timeout is enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int  DATA_WIDTH     = 32,
    parameter int  ADDR_WIDTH     = 12,
    parameter int  NUM_SLAVES     = 4,
    parameter int  SEL_BITS       = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1,
    parameter int  TIMEOUT_CYCLES = 256,
    localparam int STRB_WIDTH     = strb_width(DATA_WIDTH)
) (
    input  logic                             PCLK,
    input  logic                             PRESETn,
    input  logic                             cmd_valid,
    output logic                             cmd_ready,
    input  logic                             cmd_write,
    input  logic [ADDR_WIDTH-1:0]            cmd_addr,
    input  logic [DATA_WIDTH-1:0]            cmd_wdata,
    input  logic [STRB_WIDTH-1:0]            cmd_strb,
    input  logic [PROT_WIDTH-1:0]            cmd_prot,
    output logic                             rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic                             rsp_err,
    output logic [NUM_SLAVES-1:0]            PSELx,
    output logic                             PENABLE,
    output logic [ADDR_WIDTH-1:0]            PADDR,
    output logic                             PWRITE,
    output logic [DATA_WIDTH-1:0]            PWDATA,
    output logic [STRB_WIDTH-1:0]            PSTRB,
    output logic [PROT_WIDTH-1:0]            PPROT,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA,
    input  logic [NUM_SLAVES-1:0]            PREADY,
    input  logic [NUM_SLAVES-1:0]            PSLVERR
);

    apb_state_e state_q, state_d;

    logic                  cmd_ready_q, cmd_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q,   rsp_err_d;
    logic [NUM_SLAVES-1:0] psel_q,      psel_d;
    logic                  penable_q,   penable_d;
    logic [ADDR_WIDTH-1:0] paddr_q,     paddr_d;
    logic                  pwrite_q,    pwrite_d;
    logic [DATA_WIDTH-1:0] pwdata_q,    pwdata_d;
    logic [STRB_WIDTH-1:0] pstrb_q,     pstrb_d;
    logic [PROT_WIDTH-1:0] pprot_q,     pprot_d;

    logic [NUM_SLAVES-1:0] dec_sel;
    logic                  dec_err;
    logic                  slave_ready;
    logic                  slave_err;
    logic [DATA_WIDTH-1:0] slave_rdata;
    logic                  timeout_hit;

    apb_slave_decoder #(
        .NUM_SLAVES (NUM_SLAVES),
        .SEL_BITS   (SEL_BITS)
    ) u_decoder (
        .idx        (cmd_addr[ADDR_WIDTH-1 -: SEL_BITS]),
        .sel        (dec_sel),
        .decode_err (dec_err)
    );

    // Completer responses are qualified by the registered select, so idle slaves are ignored.
    assign slave_ready = |(PREADY & psel_q);
    assign slave_err   = |(PSLVERR & psel_q);

    always_comb begin
        slave_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (psel_q[i]) begin
                slave_rdata = slave_rdata | PRDATA[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    always_comb begin
        to_cnt_d = '0;
        if (state_q == ACCESS && !slave_ready) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    // A ready on the expiry edge takes priority in the FSM, so this only fires on a true stall.
    assign timeout_hit = (state_q == ACCESS) && !slave_ready &&
                         (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        pstrb_d     = pstrb_q;
        pprot_d     = pprot_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    if (dec_err) begin
                        state_d     = DONE;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else begin
                        state_d  = SETUP;
                        psel_d   = dec_sel;
                        paddr_d  = cmd_addr;
                        pwrite_d = cmd_write;
                        pwdata_d = cmd_write ? cmd_wdata : '0;
                        pstrb_d  = cmd_write ? cmd_strb : '0;
                        pprot_d  = cmd_prot;
                    end
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                if (slave_ready) begin
                    state_d     = DONE;
                    psel_d      = '0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = slave_err;
                    rsp_rdata_d = (!pwrite_q && !slave_err) ? slave_rdata : '0;
                end else if (timeout_hit) begin
                    state_d     = DONE;
                    psel_d      = '0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered ready: high exactly in cycles where the FSM sits in IDLE after reset release.
        cmd_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            pprot_q     <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            pstrb_q     <= pstrb_d;
            pprot_q     <= pprot_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign PSELx     = psel_q;
    assign PENABLE   = penable_q;
    assign PADDR     = paddr_q;
    assign PWRITE    = pwrite_q;
    assign PWDATA    = pwdata_q;
    assign PSTRB     = pstrb_q;
    assign PPROT     = pprot_q;

endmodule
